// File: rtl/bcd_conv_dd.sv
// Binary-to-BCD double-dabble converter with optional two's-complement input and overflow flag.
// Latency 2*N_BITS+1 edges from accepted INIT to DONE; INIT is ignored while BUSY (no queueing).
module bcd_conv_dd #(
    parameter int N_BITS    = 16,
    parameter int N_DIGITS  = 5,
    parameter int SIGNED_EN = 0,
    parameter int DONE_HOLD = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    INIT,
    input  logic [N_BITS-1:0]       BIN,
    output logic [4*N_DIGITS-1:0]   BCD,
    output logic                    SIGN,
    output logic                    OVF,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int DW = 4 * N_DIGITS;
    localparam int SW = DW + N_BITS;
    localparam logic [5:0] CNT_INIT  = 6'(N_BITS);
    localparam logic [7:0] HOLD_INIT = 8'(DONE_HOLD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADJ   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [N_BITS-1:0] op_r;
    logic [N_BITS-1:0] op_mag;
    logic [SW-1:0]     sr;
    logic [SW-1:0]     sr_adj;
    logic [SW-1:0]     sr_shl;
    logic [5:0]        cnt;
    logic [7:0]        hold;
    logic              sign_r;
    logic              ovf_r;
    logic              ovf_nxt;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign op_mag  = (SIGNED_EN != 0 && op_r[N_BITS-1]) ? -op_r : op_r;
    assign sr_shl  = {sr[SW-2:0], 1'b0};
    assign ovf_nxt = ovf_r | sr[SW-1];

    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (sr[N_BITS+4*d +: 4] >= 4'd5) begin
                sr_adj[N_BITS+4*d +: 4] = sr[N_BITS+4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = INIT ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                BUSY      = 1'b1;
                state_nxt = S_ADJ;
            end
            S_ADJ: begin
                BUSY      = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                BUSY      = 1'b1;
                state_nxt = (cnt == 6'd1) ? S_DONE : S_ADJ;
            end
            S_DONE: begin
                DONE = 1'b1;
                if (INIT) begin
                    state_nxt = S_LOAD;
                end else if (hold <= 8'd1) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_r   <= '0;
            sr     <= '0;
            cnt    <= '0;
            hold   <= '0;
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
            BCD    <= '0;
            SIGN   <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (INIT) op_r <= BIN;
                end
                S_LOAD: begin
                    sr     <= {{DW{1'b0}}, op_mag};
                    sign_r <= (SIGNED_EN != 0) ? op_r[N_BITS-1] : 1'b0;
                    ovf_r  <= 1'b0;
                    cnt    <= CNT_INIT;
                end
                S_ADJ: begin
                    sr <= sr_adj;
                end
                S_SHIFT: begin
                    sr    <= sr_shl;
                    ovf_r <= ovf_nxt;
                    cnt   <= cnt - 6'd1;
                    // Results publish on the edge that enters S_DONE, so DONE and BCD rise together.
                    if (cnt == 6'd1) begin
                        BCD  <= sr_shl[SW-1 -: DW];
                        SIGN <= sign_r;
                        OVF  <= ovf_nxt;
                        hold <= HOLD_INIT;
                    end
                end
                S_DONE: begin
                    if (INIT) begin
                        op_r <= BIN;
                    end else begin
                        hold <= hold - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
